// File: rtl/otter_io_pkg.sv
// rtl/otter_io_pkg.sv - register map, STATUS bit positions and TX FSM states for the OTTER UART.
package otter_io_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;
  localparam logic [31:0] CTRL_OFS   = 32'h8;
  localparam logic [31:0] DIV_OFS    = 32'hC;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// rtl/io_sync_fifo.sv - synchronous FIFO; pop on empty is ignored, push on full is accepted only with a pop.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_push && !do_pop) level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/otter_io_uart_tx.sv
// rtl/otter_io_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and empty-and-idle interrupt.
module otter_io_uart_tx
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iobus_addr,
  input  logic [31:0] iobus_out,
  input  logic        iobus_wr,
  output logic [31:0] iobus_in,
  output logic        rd_hit,
  output logic        tx,
  output logic        intr
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;
  logic        intr_q, intr_d;
  logic        ovf_q, ovf_d;
  logic        intr_en_q, intr_en_d;
  logic [15:0] div_q, div_d;

  logic          sel_txdata, sel_status, sel_ctrl, sel_div;
  logic          push, pop, busy;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [15:0]   reload;
  logic          unused_iobus_out;

  assign sel_txdata = (iobus_addr == BASE_ADDR + TXDATA_OFS);
  assign sel_status = (iobus_addr == BASE_ADDR + STATUS_OFS);
  assign sel_ctrl   = (iobus_addr == BASE_ADDR + CTRL_OFS);
  assign sel_div    = (iobus_addr == BASE_ADDR + DIV_OFS);
  assign rd_hit     = sel_txdata | sel_status | sel_ctrl | sel_div;

  assign push   = iobus_wr & sel_txdata;
  assign busy   = (state_q != IDLE);
  // A divisor of 0 behaves as 1 so a bit always lasts at least one cycle.
  assign reload = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign unused_iobus_out = ^iobus_out[31:16];

  io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (iobus_out[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_dout;
          state_d = START;
          cnt_d   = reload;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          cnt_d     = reload;
          tx_d      = data_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = reload;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = data_q[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = fifo_dout;
            state_d = START;
            cnt_d   = reload;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    intr_en_d = intr_en_q;
    div_d     = div_q;
    ovf_d     = ovf_q;
    if (iobus_wr && sel_ctrl) intr_en_d = iobus_out[0];
    if (iobus_wr && sel_div)  div_d     = iobus_out[15:0];
    if (iobus_wr && sel_status && iobus_out[ST_OVF_BIT]) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    intr_d = intr_en_q & fifo_empty & ~busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      intr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      intr_en_q <= 1'b0;
      div_q     <= DEFAULT_DIV;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      intr_q    <= intr_d;
      ovf_q     <= ovf_d;
      intr_en_q <= intr_en_d;
      div_q     <= div_d;
    end
  end

  always_comb begin
    iobus_in = 32'h0;
    if (sel_status) begin
      iobus_in[15:8]         = 8'(fifo_level);
      iobus_in[ST_OVF_BIT]   = ovf_q;
      iobus_in[ST_BUSY_BIT]  = busy;
      iobus_in[ST_FULL_BIT]  = fifo_full;
      iobus_in[ST_EMPTY_BIT] = fifo_empty;
    end else if (sel_ctrl) begin
      iobus_in[0] = intr_en_q;
    end else if (sel_div) begin
      iobus_in[15:0] = div_q;
    end
  end

  assign tx   = tx_q;
  assign intr = intr_q;

endmodule

// File: tb/tb_otter_io_uart_tx.sv
// tb/tb_otter_io_uart_tx.sv - self-checking bench for otter_io_uart_tx: register vectors plus serial frame scoreboard.
module tb_otter_io_uart_tx;

  localparam logic [31:0] BASE = 32'h1100_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  logic        rd_hit;
  logic        tx;
  logic        intr;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        hit;
  } vec_t;

  vec_t vecs[13];

  otter_io_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .iobus_addr (iobus_addr),
    .iobus_out  (iobus_out),
    .iobus_wr   (iobus_wr),
    .iobus_in   (iobus_in),
    .rd_hit     (rd_hit),
    .tx         (tx),
    .intr       (intr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    iobus_addr = a;
    iobus_out  = d;
    iobus_wr   = 1'b1;
    tick();
    iobus_wr   = 1'b0;
    iobus_addr = 32'h0;
    iobus_out  = 32'h0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    sb_q.push_back(b);
    wr_reg(BASE, {24'h0, b});
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a,
                        input logic [31:0] exp, input logic exp_hit);
    iobus_addr = a;
    #1;
    chk(name, iobus_in, exp);
    chk({name, "_hit"}, {31'h0, rd_hit}, {31'h0, exp_hit});
    iobus_addr = 32'h0;
  endtask

  // Pops the next expected byte and checks every cycle of its frame; STATUS.busy is watched throughout.
  task automatic expect_frame(input int div, input int exp_wait, input bit last);
    logic [7:0] b;
    logic [9:0] bits;
    int         waited;
    bit         bad;
    bit         busy_bad;
    if (sb_q.size() == 0) begin
      chk("scoreboard_has_entry", 32'd0, 32'd1);
      return;
    end
    b          = sb_q.pop_front();
    bits       = {1'b1, b, 1'b0};
    iobus_addr = BASE + 32'h4;
    waited     = 0;
    while (tx !== 1'b0 && waited < 200) begin
      tick();
      waited++;
    end
    chk($sformatf("start_wait_%02h", b), 32'(waited), 32'(exp_wait));
    if (tx !== 1'b0) return;
    busy_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bad = 1'b0;
      for (int c = 0; c < div; c++) begin
        #1;
        if (tx !== bits[i]) bad = 1'b1;
        if (iobus_in[2] !== 1'b1) busy_bad = 1'b1;
        tick();
      end
      chk($sformatf("frame_%02h_bit%0d_wrong", b, i), {31'h0, bad}, 32'h0);
    end
    chk($sformatf("frame_%02h_busy_dropped", b), {31'h0, busy_bad}, 32'h0);
    if (last) begin
      #1;
      chk($sformatf("frame_%02h_busy_after", b), {31'h0, iobus_in[2]}, 32'h0);
      chk($sformatf("frame_%02h_tx_idle", b), {31'h0, tx}, 32'h1);
    end
    iobus_addr = 32'h0;
  endtask

  initial begin
    bit tx_bad;

    vecs[0]  = '{"rst_status",   1'b0, 32'h0,        32'h0,         BASE + 32'h4,   32'h0000_0001, 1'b1};
    vecs[1]  = '{"rst_div",      1'b0, 32'h0,        32'h0,         BASE + 32'hC,   32'h0000_0364, 1'b1};
    vecs[2]  = '{"rst_ctrl",     1'b0, 32'h0,        32'h0,         BASE + 32'h8,   32'h0,         1'b1};
    vecs[3]  = '{"txdata_rd0",   1'b0, 32'h0,        32'h0,         BASE,           32'h0,         1'b1};
    vecs[4]  = '{"miss_wr_ctrl", 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, BASE + 32'h8,   32'h0,         1'b1};
    vecs[5]  = '{"miss_rd",      1'b0, 32'h0,        32'h0,         BASE + 32'h10,  32'h0,         1'b0};
    vecs[6]  = '{"ctrl_set",     1'b1, BASE + 32'h8, 32'hFFFF_FFFF, BASE + 32'h8,   32'h1,         1'b1};
    vecs[7]  = '{"ctrl_clr",     1'b1, BASE + 32'h8, 32'h0,         BASE + 32'h8,   32'h0,         1'b1};
    vecs[8]  = '{"div_trunc",    1'b1, BASE + 32'hC, 32'hABCD_1234, BASE + 32'hC,   32'h0000_1234, 1'b1};
    vecs[9]  = '{"div_4",        1'b1, BASE + 32'hC, 32'h4,         BASE + 32'hC,   32'h0000_0004, 1'b1};
    vecs[10] = '{"miss_wr_div",  1'b1, BASE + 32'h10, 32'h7,        BASE + 32'hC,   32'h0000_0004, 1'b1};
    vecs[11] = '{"miss_rd_far",  1'b0, 32'h0,        32'h0,         BASE + 32'h100, 32'h0,         1'b0};
    vecs[12] = '{"miss_status",  1'b0, 32'h0,        32'h0,         BASE + 32'h4,   32'h0000_0001, 1'b1};

    rst        = 1'b1;
    iobus_addr = 32'h0;
    iobus_out  = 32'h0;
    iobus_wr   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_intr", {31'h0, intr}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) wr_reg(vecs[i].waddr, vecs[i].wdata);
      rd_chk(vecs[i].name, vecs[i].raddr, vecs[i].rdata, vecs[i].hit);
    end

    // Single byte: level 1 right after the write, start bit one edge later.
    push_byte(8'hA5);
    rd_chk("a5_level1", BASE + 32'h4, 32'h0000_0100, 1'b1);
    expect_frame(4, 1, 1'b1);

    // Back-to-back frames with no gap.
    push_byte(8'h55);
    push_byte(8'h0F);
    expect_frame(4, 0, 1'b0);
    expect_frame(4, 0, 1'b1);
    rd_chk("b2b_empty", BASE + 32'h4, 32'h0000_0001, 1'b1);

    // Interrupt.
    wr_reg(BASE + 32'h8, 32'h1);
    tick();
    chk("intr_set", {31'h0, intr}, 32'h1);
    push_byte(8'h01);
    tick();
    chk("intr_drop", {31'h0, intr}, 32'h0);
    expect_frame(4, 0, 1'b1);
    chk("intr_at_stop_end", {31'h0, intr}, 32'h0);
    tick();
    chk("intr_back", {31'h0, intr}, 32'h1);
    wr_reg(BASE + 32'h8, 32'h0);
    tick();
    chk("intr_disabled", {31'h0, intr}, 32'h0);

    // Overflow with the transmitter stalled.
    wr_reg(BASE + 32'hC, 32'hFFFF);
    for (int i = 0; i < 10; i++) wr_reg(BASE, 32'(i + 16));
    rd_chk("ovf_status", BASE + 32'h4, 32'h0000_080E, 1'b1);
    wr_reg(BASE + 32'h4, 32'h8);
    rd_chk("ovf_cleared", BASE + 32'h4, 32'h0000_0806, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_chk("flush_status", BASE + 32'h4, 32'h0000_0001, 1'b1);
    rd_chk("flush_div", BASE + 32'hC, 32'h0000_0364, 1'b1);
    wr_reg(BASE + 32'hC, 32'h4);

    // Reset during DATA bit 3 of 0xF0 (that bit is 0 on the line).
    wr_reg(BASE, 32'hF0);
    for (int i = 0; i < 18; i++) tick();
    chk("mid_bit3_tx", {31'h0, tx}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_tx", {31'h0, tx}, 32'h1);
    rd_chk("mid_rst_status", BASE + 32'h4, 32'h0000_0001, 1'b1);
    tx_bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1) tx_bad = 1'b1;
      tick();
    end
    chk("mid_rst_no_resume", {31'h0, tx_bad}, 32'h0);

    // DIV=0 behaves as 1: a 10-cycle frame.
    wr_reg(BASE + 32'hC, 32'h0);
    rd_chk("div0_rd", BASE + 32'hC, 32'h0, 1'b1);
    push_byte(8'h96);
    expect_frame(1, 1, 1'b1);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
